obi_wb_bridge: RTL and testbench
================================

OBI_WB_BRIDGE -- requirements
Module: obi_wb_bridge

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, SHALL set the maximum number of accepted-but-unanswered transactions (legal 1..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 256, SHALL set the watchdog limit in clk_i cycles (used only with OBI_WB_TIMEOUT_EN).
REQ-003 Ports SHALL be, one per line:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- obi_req_i  in  1  core request.
- obi_gnt_o  out  1  request accepted this cycle.
- obi_addr_i  in  32  byte address.
- obi_we_i  in  1  1 = write.
- obi_be_i  in  4  byte enables.
- obi_wdata_i  in  32  write data.
- obi_rvalid_o  out  1  response valid.
- obi_rdata_o  out  32  read data.
- obi_err_o  out  1  response error, qualified by obi_rvalid_o.
- wb_cyc_o  out  1  bus cycle active.
- wb_stb_o  out  1  pipelined strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects.
- wb_adr_o  out  32  address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.
- wb_stall_i  in  1  slave cannot accept strobe.

Function
REQ-004 wb_stb_o SHALL equal obi_req_i AND (cnt < MAX_OUTSTANDING) AND state==ACTIVE-or-IDLE; wb_adr_o/we/sel/dat_o SHALL pass obi_addr_i/we/be/wdata combinationally.
REQ-005 obi_gnt_o SHALL equal wb_stb_o AND NOT wb_stall_i; exactly one transaction is issued per gnt cycle.
REQ-006 wb_cyc_o SHALL be 1 whenever wb_stb_o=1 or cnt>0, else 0.
REQ-007 Counter cnt (3 bits): +1 on gnt, -1 on (ack OR err) with cnt>0; gnt and ack in the same cycle SHALL leave cnt unchanged.
REQ-008 Ack/err with cnt==0 SHALL be ignored: no rvalid, cnt stays 0.
REQ-009 On accepted ack/err at edge N, obi_rvalid_o SHALL be 1 for exactly cycle N+1 with obi_rdata_o=wb_dat_i and obi_err_o=wb_err_i registered at N (latency 1, no bypass).
REQ-010 ack and err both high in one cycle SHALL count as one response with obi_err_o=1.
REQ-011 obi_rdata_o SHALL hold its last value when obi_rvalid_o=0; writes return rdata as sampled (don't-care).
REQ-012 FSM states: IDLE (cnt==0), ACTIVE (cnt>0), FLUSH; IDLE->ACTIVE on gnt; ACTIVE->IDLE when cnt reaches 0; FLUSH only per REQ-016.
REQ-013 Responses SHALL be returned in issue order; the bridge SHALL NOT reorder or buffer beyond MAX_OUTSTANDING.

Reset
REQ-014 While rst_ni=0 all outputs SHALL be 0 (obi_rdata_o=32'h0), cnt=0, state=IDLE, watchdog=0, asynchronously.
REQ-015 Reset asserted mid-transaction SHALL discard all outstanding transactions; no rvalid SHALL follow release for them.

Configuration
REQ-016 With OBI_WB_TIMEOUT_EN defined: watchdog counts cycles with cnt>0 and no ack/err, clears on any ack/err or cnt==0; on reaching TIMEOUT_CYCLES state SHALL go FLUSH, drop wb_cyc_o/wb_stb_o, hold obi_gnt_o=0, emit one obi_rvalid_o with obi_err_o=1 and obi_rdata_o=0 per outstanding transaction on consecutive cycles, ignore wb_ack_i/wb_err_i, then return to IDLE.
REQ-017 Without OBI_WB_TIMEOUT_EN: no watchdog logic, FLUSH unreachable, bridge waits indefinitely for ack.

Verification
REQ-018 Read: req, addr=0x100, stall=0, ack next cycle with dat=0xDEADBEEF -> gnt same cycle as req, rvalid one cycle after ack, rdata=0xDEADBEEF, err=0.
REQ-019 Back-pressure: stall=1 for 3 cycles with req held -> stb=1, gnt=0 for 3 cycles, gnt=1 on first stall=0 cycle, exactly one WB transaction.
REQ-020 Pipelining: 3 back-to-back reqs, MAX_OUTSTANDING=2, ack withheld -> 2 gnts, third held (stb=0) until first ack, then gnt; 3 rvalids in order.
REQ-021 Error and spurious: err on write -> rvalid with err=1; ack with cnt==0 -> no rvalid, cnt=0.
REQ-022 Timeout (macro on, TIMEOUT_CYCLES=8): 2 reads granted, no ack -> after 8 cycles cyc=0, two consecutive rvalid with err=1, state IDLE; late ack ignored.
REQ-023 Reset with cnt=2: pull rst_ni low asynchronously mid-cycle -> all outputs 0 immediately, no rvalid after release.

Source files
------------

// File: rtl/obi_wb_bridge.sv
// rtl/obi_wb_bridge.sv - OBI to pipelined Wishbone bridge with bounded outstanding transactions
// Optional watchdog/flush feature enabled by defining OBI_WB_TIMEOUT_EN.
`timescale 1ns/1ps
module obi_wb_bridge #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt, cnt_next;
    logic        stb, gnt, resp_take, flush_beat, timeout_hit;
    logic        rvalid_q, err_q;
    logic [31:0] rdata_q;

    // Combinational outputs are gated by reset so the whole port is quiet while rst_ni is low.
    assign stb        = rst_ni && obi_req_i && (cnt < 3'(MAX_OUTSTANDING)) && (state != FLUSH);
    assign gnt        = stb && !wb_stall_i;
    assign resp_take  = (wb_ack_i || wb_err_i) && (cnt != 3'd0) && (state != FLUSH);
    assign flush_beat = (state == FLUSH) && (cnt != 3'd0);

    assign obi_gnt_o    = gnt;
    assign wb_stb_o     = stb;
    assign wb_cyc_o     = rst_ni && (state != FLUSH) && (stb || (cnt != 3'd0));
    assign wb_we_o      = rst_ni && obi_we_i;
    assign wb_sel_o     = rst_ni ? obi_be_i    : 4'h0;
    assign wb_adr_o     = rst_ni ? obi_addr_i  : 32'h0;
    assign wb_dat_o     = rst_ni ? obi_wdata_i : 32'h0;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

`ifdef OBI_WB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd;
    logic            wd_run;

    assign wd_run      = (state == ACTIVE) && (cnt != 3'd0) && !(wb_ack_i || wb_err_i);
    assign timeout_hit = wd_run && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd <= '0;
        end else if (wd_run && !timeout_hit) begin
            wd <= wd + WD_W'(1);
        end else begin
            wd <= '0;
        end
    end
`else
    // Watchdog absent: the comparison is always false for legal parameter values.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        cnt_next   = cnt;
        state_next = state;
        case (state)
            IDLE: begin
                if (gnt) begin
                    cnt_next   = cnt + 3'd1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                cnt_next = cnt + 3'(gnt) - 3'(resp_take);
                if (timeout_hit) begin
                    state_next = FLUSH;
                end else if (cnt_next == 3'd0) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                if (cnt != 3'd0) begin
                    cnt_next = cnt - 3'd1;
                end
                if (cnt <= 3'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = 3'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // One response per accepted ack/err; a flush beat answers one abandoned transaction with an error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else if (flush_beat) begin
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= 32'h0;
        end else if (resp_take) begin
            rvalid_q <= 1'b1;
            err_q    <= wb_err_i;
            rdata_q  <= wb_dat_i;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// tb/tb_obi_wb_bridge.sv - directed self-checking bench for obi_wb_bridge
`timescale 1ns/1ps
module tb_obi_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, ack, err, stall;
    logic [31:0] addr, wdata, dat_in;
    logic [3:0]  be;
    logic        gnt, rvalid, rerr, cyc, stb, wb_we;
    logic [31:0] rdata, adr_o, dat_o;
    logic [3:0]  sel;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    obi_wb_bridge #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
        .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
        .obi_rdata_o(rdata), .obi_err_o(rerr),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(wb_we), .wb_sel_o(sel),
        .wb_adr_o(adr_o), .wb_dat_o(dat_o), .wb_dat_i(dat_in),
        .wb_ack_i(ack), .wb_err_i(err), .wb_stall_i(stall)
    );

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h1234;
        wdata = 32'hFFFF; ack = 1'b0; err = 1'b0; stall = 1'b0; dat_in = 32'h0;
        #1;
        n_cmp++; if ({gnt, stb, cyc, wb_we, rvalid, rerr} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 000000", {gnt, stb, cyc, wb_we, rvalid, rerr});
        end
        n_cmp++; if (adr_o !== 32'h0 || dat_o !== 32'h0 || sel !== 4'h0) begin
            n_bad++; $display("FAIL reset_bus adr=%h dat=%h sel=%h want 0", adr_o, dat_o, sel);
        end
        n_cmp++; if (rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata got %h want 0", rdata);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; req = 1'b0; we = 1'b0;
    endtask

    task automatic test_read();
        @(negedge clk); req = 1'b1; addr = 32'h100; we = 1'b0; be = 4'hF; #1;
        n_cmp++; if (gnt !== 1'b1 || cyc !== 1'b1 || adr_o !== 32'h100) begin
            n_bad++; $display("FAIL read_issue gnt=%b cyc=%b adr=%h want 1 1 100", gnt, cyc, adr_o);
        end
        @(negedge clk); req = 1'b0; ack = 1'b1; dat_in = 32'hDEADBEEF; #1;
        n_cmp++; if (rvalid !== 1'b0) begin
            n_bad++; $display("FAIL read_no_bypass rvalid=%b want 0", rvalid);
        end
        @(negedge clk); ack = 1'b0; dat_in = 32'h0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rerr !== 1'b0) begin
            n_bad++; $display("FAIL read_resp rvalid=%b rdata=%h err=%b want 1 deadbeef 0", rvalid, rdata, rerr);
        end
        n_cmp++; if (cyc !== 1'b0) begin
            n_bad++; $display("FAIL read_cyc_drop cyc=%b want 0", cyc);
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL read_hold rvalid=%b rdata=%h want 0 deadbeef", rvalid, rdata);
        end
    endtask

    task automatic test_back_pressure();
        int nrv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req = 1'b1; addr = 32'h200; stall = 1'b1; #1;
            n_cmp++; if (stb !== 1'b1 || gnt !== 1'b0) begin
                n_bad++; $display("FAIL bp_stall%0d stb=%b gnt=%b want 1 0", i, stb, gnt);
            end
        end
        @(negedge clk); stall = 1'b0; #1;
        n_cmp++; if (gnt !== 1'b1) begin
            n_bad++; $display("FAIL bp_release gnt=%b want 1", gnt);
        end
        @(negedge clk); req = 1'b0; ack = 1'b1; dat_in = 32'h0BAD_F00D; #1;
        n_cmp++; if (stb !== 1'b0 || cyc !== 1'b1) begin
            n_bad++; $display("FAIL bp_wait stb=%b cyc=%b want 0 1", stb, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ack = 1'b0; #1;
            if (rvalid === 1'b1) nrv++;
        end
        n_cmp++; if (nrv !== 1) begin
            n_bad++; $display("FAIL bp_one_txn rvalids=%0d want 1", nrv);
        end
    endtask

    task automatic test_pipeline();
        @(negedge clk); req = 1'b1; addr = 32'h300; #1;
        n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL pipe_g1 gnt=%b want 1", gnt); end
        @(negedge clk); addr = 32'h304; #1;
        n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL pipe_g2 gnt=%b want 1", gnt); end
        @(negedge clk); addr = 32'h308; #1;
        n_cmp++; if (stb !== 1'b0 || gnt !== 1'b0) begin
            n_bad++; $display("FAIL pipe_full stb=%b gnt=%b want 0 0", stb, gnt);
        end
        @(negedge clk); ack = 1'b1; dat_in = 32'h1; #1;
        n_cmp++; if (stb !== 1'b0) begin n_bad++; $display("FAIL pipe_full_ack stb=%b want 0", stb); end
        @(negedge clk); dat_in = 32'h2; #1;
        n_cmp++; if (gnt !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h1) begin
            n_bad++; $display("FAIL pipe_g3 gnt=%b rvalid=%b rdata=%h want 1 1 1", gnt, rvalid, rdata);
        end
        @(negedge clk); req = 1'b0; dat_in = 32'h3; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h2) begin
            n_bad++; $display("FAIL pipe_r2 rvalid=%b rdata=%h want 1 2", rvalid, rdata);
        end
        @(negedge clk); ack = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h3) begin
            n_bad++; $display("FAIL pipe_r3 rvalid=%b rdata=%h want 1 3", rvalid, rdata);
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 1'b0 || cyc !== 1'b0) begin
            n_bad++; $display("FAIL pipe_end rvalid=%b cyc=%b want 0 0", rvalid, cyc);
        end
    endtask

    task automatic test_error_spurious();
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 32'h400; be = 4'h3; wdata = 32'hA5A5_0000; #1;
        n_cmp++; if (gnt !== 1'b1 || wb_we !== 1'b1 || sel !== 4'h3 || dat_o !== 32'hA5A5_0000) begin
            n_bad++; $display("FAIL wr_issue gnt=%b we=%b sel=%h dat=%h want 1 1 3 a5a50000", gnt, wb_we, sel, dat_o);
        end
        @(negedge clk); req = 1'b0; we = 1'b0; err = 1'b1; #1;
        @(negedge clk); err = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rerr !== 1'b1) begin
            n_bad++; $display("FAIL wr_err rvalid=%b err=%b want 1 1", rvalid, rerr);
        end
        @(negedge clk); req = 1'b1; addr = 32'h404; be = 4'hF; #1;
        @(negedge clk); req = 1'b0; ack = 1'b1; err = 1'b1; dat_in = 32'h55; #1;
        @(negedge clk); ack = 1'b0; err = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b1 || rerr !== 1'b1 || rdata !== 32'h55) begin
            n_bad++; $display("FAIL ack_and_err rvalid=%b err=%b rdata=%h want 1 1 55", rvalid, rerr, rdata);
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL ack_and_err_once rvalid=%b want 0", rvalid); end
        @(negedge clk); ack = 1'b1; dat_in = 32'h77; #1;
        @(negedge clk); ack = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b0 || cyc !== 1'b0 || rdata !== 32'h55) begin
            n_bad++; $display("FAIL spurious rvalid=%b cyc=%b rdata=%h want 0 0 55", rvalid, cyc, rdata);
        end
        // two fresh grants then a stall proves the spurious ack left cnt at 0
        @(negedge clk); req = 1'b1; addr = 32'h500; #1;
        @(negedge clk); #1;
        n_cmp++; if (gnt !== 1'b1) begin n_bad++; $display("FAIL spurious_cnt_g2 gnt=%b want 1", gnt); end
        @(negedge clk); #1;
        n_cmp++; if (stb !== 1'b0) begin n_bad++; $display("FAIL spurious_cnt_full stb=%b want 0", stb); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #2; rst_n = 1'b0; #1;
        n_cmp++; if ({gnt, stb, cyc, rvalid, rerr} !== 5'b0 || rdata !== 32'h0 || adr_o !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid ctrl=%b rdata=%h adr=%h want 0", {gnt, stb, cyc, rvalid, rerr}, rdata, adr_o);
        end
        @(negedge clk); rst_n = 1'b1; req = 1'b0; ack = 1'b1; #1;
        n_cmp++; if (cyc !== 1'b0) begin n_bad++; $display("FAIL rst_release_cyc cyc=%b want 0", cyc); end
        @(negedge clk); ack = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_no_rvalid rvalid=%b want 0", rvalid); end
    endtask

`ifdef OBI_WB_TIMEOUT_EN
    task automatic test_timeout();
        int first = -1;
        @(negedge clk); req = 1'b1; addr = 32'h600; #1;
        @(negedge clk); #1;
        @(negedge clk); req = 1'b0; #1;
        for (int i = 1; i < 40 && first < 0; i++) begin
            @(negedge clk); #1;
            if (rvalid === 1'b1) first = i;
        end
        n_cmp++; if (first !== 8) begin n_bad++; $display("FAIL to_latency first_rvalid=%0d want 8", first); end
        n_cmp++; if (rerr !== 1'b1 || rdata !== 32'h0 || cyc !== 1'b0) begin
            n_bad++; $display("FAIL to_beat1 err=%b rdata=%h cyc=%b want 1 0 0", rerr, rdata, cyc);
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 1'b1 || rerr !== 1'b1) begin
            n_bad++; $display("FAIL to_beat2 rvalid=%b err=%b want 1 1", rvalid, rerr);
        end
        @(negedge clk); ack = 1'b1; #1;
        @(negedge clk); ack = 1'b0; #1;
        n_cmp++; if (rvalid !== 1'b0 || cyc !== 1'b0) begin
            n_bad++; $display("FAIL to_late_ack rvalid=%b cyc=%b want 0 0", rvalid, cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_back_pressure();
        test_pipeline();
        test_error_spurious();
        test_reset_mid();
`ifdef OBI_WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
